pll_lock_supervisor: RTL and testbench

Consumes the LOCK output of the rPLL clock generator. Sequences the PLL's RESET input and releases a clean, debounced synchronous reset to downstream logic only after lock has been stable for a programmable time. Detects lock loss and lock-acquire timeout, retries the PLL, and keeps saturating event counters for debug. Runs on the free-running 27 MHz board clock, not on a PLL output.

---
 rtl/pll_lock_supervisor.sv | 197 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the RESET input of a PLL from its LOCK output. The block runs on
//   the free-running reference clock. It holds the PLL in reset for a fixed
//   time and then waits for lock. Lock must then stay stable for a
//   programmable time before the downstream reset is released. Lock loss and
//   acquire timeout both send the PLL back through the sequence. Saturating
//   event counters are kept for debug.
//
// Ports
//   clk          free-running reference clock (not a PLL output)
//   rst_n        synchronous active-low reset
//   pll_lock_i   PLL LOCK, asynchronous to clk
//   clr_cnt_i    synchronous clear of both event counters
//   pll_reset_o  PLL RESET, active-high
//   sys_rst_n_o  downstream reset, active-low
//   locked_o     high only in RUN (same as sys_rst_n_o)
//   state_o      0=PLL_RST, 1=WAIT, 2=STAB, 3=RUN
//   loss_cnt_o   saturating count of RUN->WAIT lock losses
//   retry_cnt_o  saturating count of WAIT timeouts
module pll_lock_supervisor #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 270000,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_lock_i,
   input  logic             clr_cnt_i,
   output logic             pll_reset_o,
   output logic             sys_rst_n_o,
   output logic             locked_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] loss_cnt_o,
   output logic [CNT_W-1:0] retry_cnt_o
);

   typedef enum logic [1:0] {
      ST_PLL_RST = 2'd0,
      ST_WAIT    = 2'd1,
      ST_STAB    = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   // The shared cycle timer must hold the longest of the three intervals.
   localparam int MAX_AB  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
   localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);

   localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] STAB_LAST = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Saturating increment for the debug event counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   lock_s;
   state_t                 state_q, state_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic [CNT_W-1:0]       loss_q, loss_d;
   logic [CNT_W-1:0]       retry_q, retry_d;
   logic                   pll_reset_q, pll_reset_d;
   logic                   sys_rst_n_q, sys_rst_n_d;
   logic                   locked_q, locked_d;
   logic                   loss_ev_s;
   logic                   retry_ev_s;

   assign lock_s = sync_q[SYNC_STAGES-1];

   // Next-state, timer, counter and output decode.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], pll_lock_i};
      state_d    = state_q;
      loss_ev_s  = 1'b0;
      retry_ev_s = 1'b0;

      case (state_q)
         ST_PLL_RST: begin
            // lock_s is deliberately ignored while the PLL is held in reset.
            if (tmr_q == RST_LAST) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_PLL_RST;
            end
         end
         ST_WAIT: begin
            // Lock takes priority over a coincident timeout.
            if (lock_s) begin
               state_d = ST_STAB;
            end else if (tmr_q == TO_LAST) begin
               state_d    = ST_PLL_RST;
               retry_ev_s = 1'b1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_STAB: begin
            if (!lock_s) begin
               state_d = ST_WAIT;
            end else if (tmr_q == STAB_LAST) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_STAB;
            end
         end
         ST_RUN: begin
            // No filtering: a single low cycle of lock_s drops the reset.
            if (!lock_s) begin
               state_d   = ST_WAIT;
               loss_ev_s = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_PLL_RST;
         end
      endcase

      // The timer restarts on every transition and otherwise counts up,
      // holding at its maximum so a long RUN never wraps it.
      if (state_d != state_q) begin
         tmr_d = '0;
      end else if (tmr_q == TMR_MAX) begin
         tmr_d = tmr_q;
      end else begin
         tmr_d = tmr_q + TMR_ONE;
      end

      // Clear wins over a coincident increment.
      if (clr_cnt_i) begin
         loss_d = '0;
      end else if (loss_ev_s) begin
         loss_d = sat_inc(loss_q);
      end else begin
         loss_d = loss_q;
      end

      if (clr_cnt_i) begin
         retry_d = '0;
      end else if (retry_ev_s) begin
         retry_d = sat_inc(retry_q);
      end else begin
         retry_d = retry_q;
      end

      // Outputs are decoded from the next state so they move with state_o.
      pll_reset_d = (state_d == ST_PLL_RST);
      sys_rst_n_d = (state_d == ST_RUN);
      locked_d    = (state_d == ST_RUN);
   end

   // State, synchronizer, timer, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q      <= '0;
         state_q     <= ST_PLL_RST;
         tmr_q       <= '0;
         loss_q      <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         loss_q      <= loss_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_n_q <= sys_rst_n_d;
         locked_q    <= locked_d;
      end
   end

   assign pll_reset_o = pll_reset_q;
   assign sys_rst_n_o = sys_rst_n_q;
   assign locked_o    = locked_q;
   assign state_o     = state_q;
   assign loss_cnt_o  = loss_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed scenarios followed by randomized lock/clear/reset stimulus. Every
//   cycle the DUT outputs are compared with a behavioural model that tracks a
//   phase, the time spent in it and a queue of past lock samples.
module tb_pll_lock_supervisor;

   localparam int SYNC  = 2;
   localparam int PRC   = 4;
   localparam int STB   = 8;
   localparam int TMO   = 32;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_RUN  = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pll_lock_i;
   logic          clr_cnt_i;
   logic          pll_reset_o;
   logic          sys_rst_n_o;
   logic          locked_o;
   logic [1:0]    state_o;
   logic [CW-1:0] loss_cnt_o;
   logic [CW-1:0] retry_cnt_o;

   pll_lock_supervisor #(
      .SYNC_STAGES    (SYNC),
      .PLL_RST_CYCLES (PRC),
      .STABLE_CYCLES  (STB),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_lock_i  (pll_lock_i),
      .clr_cnt_i   (clr_cnt_i),
      .pll_reset_o (pll_reset_o),
      .sys_rst_n_o (sys_rst_n_o),
      .locked_o    (locked_o),
      .state_o     (state_o),
      .loss_cnt_o  (loss_cnt_o),
      .retry_cnt_o (retry_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // behavioural model
   int m_phase  = P_RST;
   int m_time   = 1;
   int m_loss   = 0;
   int m_retry  = 0;
   int m_q[$];

   // observation helpers
   int st_trace[$];
   int prev_state     = -1;
   bit prev_pr        = 1'b0;
   bit prev_sys       = 1'b0;
   int run_len        = 0;
   int last_pulse_len = 0;
   int last_rise      = 0;
   int last_period    = 0;
   int sys_rise_edge  = 0;
   bit sys_rise_seen  = 1'b0;
   bit sys_hi_seen    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic l, input logic c);
      int nxt;
      int ls;
      int lev;
      int rev;
      if (!r) begin
         m_phase = P_RST;
         m_time  = 1;
         m_loss  = 0;
         m_retry = 0;
         m_q     = {};
         for (int i = 0; i < SYNC; i++) m_q.push_back(0);
      end else begin
         ls  = m_q[SYNC-1];
         nxt = m_phase;
         lev = 0;
         rev = 0;
         if (m_phase == P_RST) begin
            if (m_time == PRC) nxt = P_WAIT;
         end else if (m_phase == P_WAIT) begin
            if (ls == 1) nxt = P_STAB;
            else if (m_time == TMO) begin nxt = P_RST; rev = 1; end
         end else if (m_phase == P_STAB) begin
            if (ls == 0) nxt = P_WAIT;
            else if (m_time == STB) nxt = P_RUN;
         end else begin
            if (ls == 0) begin nxt = P_WAIT; lev = 1; end
         end
         if (c) begin
            m_loss  = 0;
            m_retry = 0;
         end else begin
            m_loss  = (m_loss + lev > CMAX) ? CMAX : m_loss + lev;
            m_retry = (m_retry + rev > CMAX) ? CMAX : m_retry + rev;
         end
         m_time  = (nxt != m_phase) ? 1 : m_time + 1;
         m_phase = nxt;
         m_q.push_front(int'(l));
         void'(m_q.pop_back());
      end
   endtask

   task automatic step(input logic r, input logic l, input logic c);
      rst_n      = r;
      pll_lock_i = l;
      clr_cnt_i  = c;
      @(posedge clk);
      cyc++;
      model_edge(r, l, c);
      #1;
      chk("state",     32'(state_o),     32'(m_phase));
      chk("pll_reset", 32'(pll_reset_o), 32'(m_phase == P_RST));
      chk("sys_rst_n", 32'(sys_rst_n_o), 32'(m_phase == P_RUN));
      chk("locked",    32'(locked_o),    32'(m_phase == P_RUN));
      chk("loss_cnt",  32'(loss_cnt_o),  32'(m_loss));
      chk("retry_cnt", 32'(retry_cnt_o), 32'(m_retry));
      if (int'(state_o) != prev_state) begin
         st_trace.push_back(int'(state_o));
         prev_state = int'(state_o);
      end
      if (pll_reset_o === 1'b1) begin
         if (!prev_pr) begin
            last_period = cyc - last_rise;
            last_rise   = cyc;
         end
         run_len++;
      end else if (prev_pr) begin
         last_pulse_len = run_len;
         run_len        = 0;
      end
      if (sys_rst_n_o === 1'b1 && !prev_sys) begin
         sys_rise_edge = cyc;
         sys_rise_seen = 1'b1;
      end
      if (sys_rst_n_o === 1'b1) sys_hi_seen = 1'b1;
      prev_pr  = (pll_reset_o === 1'b1);
      prev_sys = (sys_rst_n_o === 1'b1);
   endtask

   task automatic run_until_state(input int tgt, input logic l, input int budget, input string tag);
      int n;
      n = 0;
      while (int'(state_o) != tgt && n < budget) begin
         step(1'b1, l, 1'b0);
         n++;
      end
      chk(tag, 32'(int'(state_o) == tgt), 32'd1);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_pll_reset"}, 32'(pll_reset_o), 32'd1);
      chk({tag, "_sys_rst_n"}, 32'(sys_rst_n_o), 32'd0);
      chk({tag, "_locked"},    32'(locked_o),    32'd0);
      chk({tag, "_state"},     32'(state_o),     32'd0);
      chk({tag, "_loss"},      32'(loss_cnt_o),  32'd0);
      chk({tag, "_retry"},     32'(retry_cnt_o), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lock_edge;
      int n;
      int stab_len;
      bit saw_low;
      logic lv;
      int seg;

      rst_n      = 1'b0;
      pll_lock_i = 1'b0;
      clr_cnt_i  = 1'b0;

      // Scenario 1: nominal bring-up
      st_trace = {};
      step(1'b0, 1'b0, 1'b0);
      chk_reset_values("s1_reset");
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      lock_edge     = cyc;
      sys_rise_seen = 1'b0;
      n = 0;
      while (!sys_rise_seen && n < 40) begin
         step(1'b1, 1'b1, 1'b0);
         n++;
      end
      chk("s1_run_reached", 32'(sys_rise_seen), 32'd1);
      chk("s1_rise_delay",  32'(sys_rise_edge - lock_edge), 32'(2 + 1 + 8));
      chk("s1_pulse_len",   32'(last_pulse_len), 32'd4);
      chk("s1_trace_len",   32'(st_trace.size()), 32'd4);
      for (int i = 0; i < 4 && i < st_trace.size(); i++)
         chk("s1_trace", 32'(st_trace[i]), 32'(i));
      chk("s1_loss",  32'(loss_cnt_o),  32'd0);
      chk("s1_retry", 32'(retry_cnt_o), 32'd0);

      // Scenario 3: glitch during stabilization
      step(1'b0, 1'b1, 1'b0);
      run_until_state(P_STAB, 1'b1, 20, "s3_stab_reached");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      chk("s3_back_to_wait", 32'(state_o), 32'd1);
      run_until_state(P_STAB, 1'b1, 20, "s3_restab");
      stab_len = 1;
      n = 0;
      while (int'(state_o) == P_STAB && n < 20) begin
         step(1'b1, 1'b1, 1'b0);
         if (int'(state_o) == P_STAB) stab_len++;
         n++;
      end
      chk("s3_stab_len",  32'(stab_len), 32'd8);
      chk("s3_run",       32'(state_o),  32'd3);
      chk("s3_loss",      32'(loss_cnt_o), 32'd0);

      // Scenario 4: single-cycle lock loss in RUN
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      saw_low = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (sys_rst_n_o === 1'b0 && locked_o === 1'b0) saw_low = 1'b1;
      end
      chk("s4_reset_dropped", 32'(saw_low), 32'd1);
      chk("s4_loss",          32'(loss_cnt_o), 32'd1);
      run_until_state(P_RUN, 1'b1, 30, "s4_rerun");
      chk("s4_sys_rst_n", 32'(sys_rst_n_o), 32'd1);

      // Scenario 6: reset mid-RUN with lock held high
      st_trace = {};
      step(1'b0, 1'b1, 1'b0);
      chk_reset_values("s6_reset");
      run_until_state(P_RUN, 1'b1, 40, "s6_rerun");
      chk("s6_pulse_len", 32'(last_pulse_len), 32'd4);
      chk("s6_trace_len", 32'(st_trace.size()), 32'd4);

      // Scenario 2: timeout retry with lock low
      sys_hi_seen = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      sys_hi_seen = 1'b0;
      for (int i = 0; i < 99; i++) step(1'b1, 1'b0, 1'b0);
      chk("s2_retry",     32'(retry_cnt_o),    32'd2);
      chk("s2_pulse_len", 32'(last_pulse_len), 32'd4);
      chk("s2_period",    32'(last_period),    32'(4 + 32));
      chk("s2_sys_low",   32'(sys_hi_seen),    32'd0);

      // Scenario 5: saturation, then clear coinciding with a timeout
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5 * 36; i++) step(1'b1, 1'b0, 1'b0);
      chk("s5_saturated", 32'(retry_cnt_o), 32'd3);
      for (int i = 0; i < 35; i++) step(1'b1, 1'b0, 1'b0);
      chk("s5_hold_sat", 32'(retry_cnt_o), 32'd3);
      step(1'b1, 1'b0, 1'b1);
      chk("s5_cleared",   32'(retry_cnt_o), 32'd0);
      chk("s5_retry_rst", 32'(pll_reset_o), 32'd1);

      // Randomized phase
      n = 0;
      while (n < 3000) begin
         seg = int'($urandom_range(1, 50));
         lv  = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < seg; i++) begin
            step(($urandom_range(0, 399) != 0), lv, ($urandom_range(0, 49) == 0));
            n++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
